if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode/register-file stage.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Registers the returned word into an IF/ID pipeline register: `info`, `pc_plus4` and `valid` feed decode.
- Supports pipeline stall (with memory replay) and branch/jump redirect (with IF/ID flush).

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- NOP_WORD, 32'h0000_0000, word driven on `info` whenever `valid`=0 (sll $0,$0,0; decodes as harmless R-type).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from decode/execute; freezes PC and IF/ID.
- redirect  in  1  taken branch/jump; fetch restarts at `redirect_pc`.
- redirect_pc  in  32  byte target address for redirect.
- imem_addr  out  32  combinational byte address to instruction memory (word-aligned).
- imem_rdata  in  32  memory data; equals word at `imem_addr` of the previous cycle.
- info  out  32  IF/ID instruction word to decode.
- pc_plus4  out  32  IF/ID address of `info` + 4.
- valid  out  1  IF/ID holds a real instruction.
- misaligned  out  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Internal state:
  - `pc_q`: next address to issue.
  - `req_pc` / `req_valid`: the address issued last cycle, whose data is on `imem_rdata` now.
  - IF/ID regs: `info`, `pc_plus4`, `valid`.
  - `misaligned`.
- imem_addr (combinational), priority order:
  - `redirect` → {`redirect_pc`[31:2], 2'b00}
  - else `stall` → `req_pc`
  - else → `pc_q`
- Reset (rst=1 at edge); overrides stall and redirect:
  - `pc_q`=RESET_PC, `req_pc`=0, `req_valid`=0.
  - `info`=NOP_WORD, `pc_plus4`=0, `valid`=0, `misaligned`=0.
  - While rst is high, `imem_addr` follows the priority rule above.
- Startup latency:
  - 1st cycle after rst deasserts: issue RESET_PC.
  - Next edge: `req_valid`=1.
  - Following edge: `valid`=1 with `info`=mem[RESET_PC].
  - So the first valid instruction appears 2 cycles after reset release.
- Normal cycle (no stall, no redirect):
  - `info`<=`imem_rdata` if `req_valid`, else NOP_WORD.
  - `pc_plus4`<=`req_pc`+4; `valid`<=`req_valid`.
  - `req_pc`<=`pc_q`; `req_valid`<=1; `pc_q`<=`pc_q`+4.
  - Throughput: 1 instruction/cycle.
- Stall (stall=1, redirect=0):
  - `pc_q`, `req_pc`, `req_valid` and all IF/ID regs hold.
  - Memory re-reads `req_pc`, so on the first non-stall cycle `imem_rdata` again holds the word for `req_pc`.
  - No instruction is lost or duplicated, for any stall length.
- Redirect (redirect=1; has priority over stall):
  - Flush: `valid`<=0, `info`<=NOP_WORD; `pc_plus4` holds.
  - `req_pc`<={`redirect_pc`[31:2],2'b00}, `req_valid`<=1, `pc_q`<=aligned target+4.
  - Target instruction reaches IF/ID with `valid`=1 one edge after the redirect edge, provided no stall.
  - Back-to-back redirects: the latest one wins; each flushes.
- Misalignment:
  - If redirect=1 and `redirect_pc`[1:0]!=0: `misaligned`<=1; fetch continues at the aligned address.
  - Cleared only by rst.
- Arithmetic: PC +4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
- Outputs are registered except `imem_addr`; no combinational path from `imem_rdata` to outputs.

Test Plan:
- Reset release, mem[i]=32'h2008_0000+i (addi), no stall → `valid` rises 2 cycles after rst falls; `info` sequence 2008_0000, 2008_0001, 2008_0002 with `pc_plus4` 4, 8, 12; one word/cycle.
- Stall held 3 cycles while `info`=mem[1] → `info`/`pc_plus4` frozen at mem[1]/8; `imem_addr` stays 8 during stall; after release the next `info` is mem[2]; no skip, no repeat.
- Redirect to 0x40 while stall=1 → next edge `valid`=0, `info`=0; following edge `info`=mem[0x40>>2], `pc_plus4`=0x44.
- Redirect to 0x42 → `misaligned`=1 and stays 1; fetch from 0x40; rst clears it.
- Redirect on consecutive cycles to 0x80 then 0xC0 → `valid` stays 0 for both; first valid `info`=mem[0xC0>>2].
- rst asserted mid-stream with stall=1 and redirect=1 → next edge all outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and registers the returned word into the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] info,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        misaligned
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] info_q, info_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] target_pc;

    assign target_pc = {redirect_pc[31:2], 2'b00};

    // While stalled the memory re-reads req_pc so its data is still on
    // imem_rdata when the stall lifts.
    always_comb begin
        if (redirect) begin
            imem_addr = target_pc;
        end else if (stall) begin
            imem_addr = req_pc_q;
        end else begin
            imem_addr = pc_q;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        req_valid_d  = req_valid_q;
        info_d       = info_q;
        pc_plus4_d   = pc_plus4_q;
        valid_d      = valid_q;
        misaligned_d = misaligned_q;

        if (redirect) begin
            valid_d     = 1'b0;
            info_d      = NOP_WORD;
            req_pc_d    = target_pc;
            req_valid_d = 1'b1;
            pc_d        = target_pc + 32'd4;
            if (redirect_pc[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
            end
        end else if (!stall) begin
            info_d      = req_valid_q ? imem_rdata : NOP_WORD;
            pc_plus4_d  = req_pc_q + 32'd4;
            valid_d     = req_valid_q;
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'h0000_0000;
            req_valid_q  <= 1'b0;
            info_q       <= NOP_WORD;
            pc_plus4_q   <= 32'h0000_0000;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            req_valid_q  <= req_valid_d;
            info_q       <= info_d;
            pc_plus4_q   <= pc_plus4_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign info       = info_q;
    assign pc_plus4   = pc_plus4_q;
    assign valid      = valid_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: startup, stall replay, redirect/flush,
// misalignment, back-to-back redirects, PC wrap and mid-stream reset.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] info;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .info       (info),
        .pc_plus4   (pc_plus4),
        .valid      (valid),
        .misaligned (misaligned)
    );

    // Synchronous memory: word at byte address a is 32'h2008_0000 + a/4.
    always @(posedge clk) imem_rdata <= 32'h2008_0000 + (imem_addr >> 2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (info !== 32'h0) begin errors++; $display("FAIL reset_info got=%h exp=00000000", info); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc_plus4 got=%h exp=00000000", pc_plus4); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%b exp=0", misaligned); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got=%h exp=00000000", imem_addr); end
    endtask

    task automatic test_startup();
        rst = 1'b0;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL start_valid_e1 got=%b exp=0", valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL start_addr_e1 got=%h exp=00000004", imem_addr); end
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL start_valid_e2 got=%b exp=1", valid); end
        checks++; if (info !== 32'h2008_0000) begin errors++; $display("FAIL start_info0 got=%h exp=20080000", info); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL start_pc4_0 got=%h exp=00000004", pc_plus4); end
        tick();
        checks++; if (info !== 32'h2008_0001) begin errors++; $display("FAIL start_info1 got=%h exp=20080001", info); end
        checks++; if (pc_plus4 !== 32'h8) begin errors++; $display("FAIL start_pc4_1 got=%h exp=00000008", pc_plus4); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr_pre got=%h exp=00000008", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (info !== 32'h2008_0001 || pc_plus4 !== 32'h8 || valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d info=%h pc4=%h valid=%b exp=20080001/00000008/1", i, info, pc_plus4, valid);
            end
            checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr%0d got=%h exp=00000008", i, imem_addr); end
        end
        stall = 1'b0;
        tick();
        checks++; if (info !== 32'h2008_0002 || pc_plus4 !== 32'hC) begin
            errors++; $display("FAIL stall_release info=%h pc4=%h exp=20080002/0000000c", info, pc_plus4);
        end
        tick();
        checks++; if (info !== 32'h2008_0003 || pc_plus4 !== 32'h10) begin
            errors++; $display("FAIL stall_next info=%h pc4=%h exp=20080003/00000010", info, pc_plus4);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got=%h exp=00000040", imem_addr); end
        tick();
        checks++; if (valid !== 1'b0 || info !== 32'h0 || pc_plus4 !== 32'h10) begin
            errors++; $display("FAIL redir_flush valid=%b info=%h pc4=%h exp=0/00000000/00000010", valid, info, pc_plus4);
        end
        stall = 1'b0; redirect = 1'b0;
        tick();
        checks++; if (valid !== 1'b1 || info !== 32'h2008_0010 || pc_plus4 !== 32'h44) begin
            errors++; $display("FAIL redir_target valid=%b info=%h pc4=%h exp=1/20080010/00000044", valid, info, pc_plus4);
        end
        tick();
        checks++; if (info !== 32'h2008_0011 || pc_plus4 !== 32'h48) begin
            errors++; $display("FAIL redir_next info=%h pc4=%h exp=20080011/00000048", info, pc_plus4);
        end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL redir_no_misalign got=%b exp=0", misaligned); end
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_pc = 32'h42;
        #1;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL mis_addr got=%h exp=00000040", imem_addr); end
        tick();
        checks++; if (misaligned !== 1'b1 || valid !== 1'b0) begin
            errors++; $display("FAIL mis_set misaligned=%b valid=%b exp=1/0", misaligned, valid);
        end
        redirect = 1'b0;
        tick();
        checks++; if (info !== 32'h2008_0010 || pc_plus4 !== 32'h44 || valid !== 1'b1) begin
            errors++; $display("FAIL mis_fetch info=%h pc4=%h valid=%b exp=20080010/00000044/1", info, pc_plus4, valid);
        end
        tick();
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sticky got=%b exp=1", misaligned); end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid1 got=%b exp=0", valid); end
        redirect_pc = 32'hC0;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid2 got=%b exp=0", valid); end
        redirect = 1'b0;
        tick();
        checks++; if (valid !== 1'b1 || info !== 32'h2008_0030 || pc_plus4 !== 32'hC4) begin
            errors++; $display("FAIL b2b_target valid=%b info=%h pc4=%h exp=1/20080030/000000c4", valid, info, pc_plus4);
        end
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL b2b_sticky got=%b exp=1", misaligned); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (info !== 32'h6007_FFFF || pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL wrap_last info=%h pc4=%h exp=6007ffff/00000000", info, pc_plus4);
        end
        tick();
        checks++; if (info !== 32'h2008_0000 || pc_plus4 !== 32'h4) begin
            errors++; $display("FAIL wrap_zero info=%h pc4=%h exp=20080000/00000004", info, pc_plus4);
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h43;
        #1;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL rst_mid_addr got=%h exp=00000040", imem_addr); end
        tick();
        checks++; if (valid !== 1'b0 || info !== 32'h0 || pc_plus4 !== 32'h0 || misaligned !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state valid=%b info=%h pc4=%h mis=%b exp=0/00000000/00000000/0", valid, info, pc_plus4, misaligned);
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_restart got=%h exp=00000000", imem_addr); end
        tick(); tick();
        checks++; if (valid !== 1'b1 || info !== 32'h2008_0000 || pc_plus4 !== 32'h4) begin
            errors++; $display("FAIL rst_mid_first valid=%b info=%h pc4=%h exp=1/20080000/00000004", valid, info, pc_plus4);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect_stall();
        test_misaligned();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
